// File: rtl/wisc_pkg.sv
// wisc_pkg: opcodes, control-field encodings and the decoded control bundle for the WISC core
package wisc_pkg;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_SLBI = 5'b10010;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RS = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;
  localparam logic [1:0] RD_R7 = 2'b11;
  localparam logic [1:0] RS_PC  = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_ALU = 2'b10;
  localparam logic [1:0] RS_IMM = 2'b11;
  localparam logic [1:0] BS_REG   = 2'b00;
  localparam logic [1:0] BS_IMM5  = 2'b01;
  localparam logic [1:0] BS_IMM8  = 2'b10;
  localparam logic [1:0] BS_SHIFT = 2'b11;
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [1:0] bsrc;
    logic [4:0] alu_op;
    logic [4:0] brin;
    logic       zext;
    logic       reg_wrt;
    logic       mem_wrt;
    logic       alu_jmp;
    logic       imm_src;
    logic [2:0] wr_reg;
    logic       is_halt;
    logic       is_nop;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/wisc_ctrl_decode.sv
// wisc_ctrl_decode: combinational opcode decode into the control bundle
// i_instr: instruction word; o_ctrl: control bundle, resolved wr_reg and status flags
module wisc_ctrl_decode
  import wisc_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] i_instr,
  output ctrl_t              o_ctrl
);
  logic [4:0] w_op;
  logic       w_unused;
  assign w_op = i_instr[INSTR_W-1 -: 5];
  assign w_unused = ^i_instr[1:0];
  always_comb begin
    o_ctrl = '0;
    o_ctrl.alu_op = w_op;
    case (w_op) inside
      5'b01000, 5'b01001: begin
        o_ctrl.reg_src = RS_ALU; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_IMM5;
      end
      5'b01010, 5'b01011, [5'b10100:5'b10111]: begin
        o_ctrl.reg_src = RS_ALU; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_IMM5; o_ctrl.zext = 1'b1;
      end
      OP_ST: begin
        o_ctrl.bsrc = BS_IMM5; o_ctrl.mem_wrt = 1'b1;
      end
      OP_LD: begin
        o_ctrl.reg_src = RS_MEM; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_IMM5;
      end
      OP_STU: begin
        o_ctrl.reg_dst = RD_RS; o_ctrl.reg_src = RS_ALU; o_ctrl.reg_wrt = 1'b1;
        o_ctrl.mem_wrt = 1'b1; o_ctrl.bsrc = BS_IMM5;
      end
      [5'b11001:5'b11111]: begin
        o_ctrl.reg_dst = RD_RD; o_ctrl.reg_src = RS_ALU; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_REG;
      end
      [5'b01100:5'b01111]: o_ctrl.brin = 5'b00001 << w_op[1:0];
      OP_LBI: begin
        o_ctrl.reg_dst = RD_RS; o_ctrl.reg_src = RS_IMM; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_IMM8;
      end
      OP_SLBI: begin
        o_ctrl.reg_dst = RD_RS; o_ctrl.reg_src = RS_IMM; o_ctrl.zext = 1'b1;
        o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_SHIFT;
      end
      OP_J: begin
        o_ctrl.brin = 5'b10000; o_ctrl.imm_src = 1'b1;
      end
      OP_JR: begin
        o_ctrl.bsrc = BS_IMM8; o_ctrl.alu_jmp = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.reg_dst = RD_R7; o_ctrl.reg_wrt = 1'b1; o_ctrl.brin = 5'b10000; o_ctrl.imm_src = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.reg_dst = RD_R7; o_ctrl.reg_wrt = 1'b1; o_ctrl.bsrc = BS_IMM8; o_ctrl.alu_jmp = 1'b1;
      end
      OP_HALT: o_ctrl.is_halt = 1'b1;
      OP_NOP: o_ctrl.is_nop = 1'b1;
      default: o_ctrl.illegal = 1'b1;
    endcase
    o_ctrl.wr_reg = o_ctrl.reg_dst == RD_RT ? i_instr[7:5] :
                    o_ctrl.reg_dst == RD_RS ? i_instr[10:8] :
                    o_ctrl.reg_dst == RD_RD ? i_instr[4:2] : 3'd7;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffered decode stage, decodes at push and queues bundles in a DEPTH-entry FIFO
// in_*: fetch handshake; out_*/control/status: head entry (all zero while out_valid=0)
// flush: empties the FIFO and clears halted; halted: sticky after a halt is accepted
module decode_stage
  import wisc_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         RegDst,
  output logic [1:0]         RegSrc,
  output logic [1:0]         Bsrc,
  output logic [4:0]         to_ALUOP,
  output logic [4:0]         brin,
  output logic               _0ext,
  output logic               RegWrt,
  output logic               MemWrt,
  output logic               ALUJmp,
  output logic               ImmSrc,
  output logic [2:0]         wr_reg,
  output logic               is_halt,
  output logic               is_nop,
  output logic               illegal,
  output logic               halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  ctrl_t              w_dec, w_head;
  ctrl_t              r_ctrl  [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_cnt;
  logic               r_halted;
  logic               w_push, w_pop;
  wisc_ctrl_decode #(.INSTR_W(INSTR_W)) u_dec (.i_instr(in_instr), .o_ctrl(w_dec));
  assign in_ready  = r_cnt != FULL && !r_halted;
  assign out_valid = r_cnt != '0;
  assign halted    = r_halted;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_halted <= 1'b0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push && w_dec.is_halt) r_halted <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_ctrl[r_wp] <= w_dec;
      r_pc[r_wp] <= in_pc;
      r_instr[r_wp] <= in_instr;
    end
  end
  assign w_head    = out_valid ? r_ctrl[r_rp] : '0;
  assign out_pc    = out_valid ? r_pc[r_rp] : '0;
  assign out_instr = out_valid ? r_instr[r_rp] : '0;
  assign RegDst    = w_head.reg_dst;
  assign RegSrc    = w_head.reg_src;
  assign Bsrc      = w_head.bsrc;
  assign to_ALUOP  = w_head.alu_op;
  assign brin      = w_head.brin;
  assign _0ext     = w_head.zext;
  assign RegWrt    = w_head.reg_wrt;
  assign MemWrt    = w_head.mem_wrt;
  assign ALUJmp    = w_head.alu_jmp;
  assign ImmSrc    = w_head.imm_src;
  assign wr_reg    = w_head.wr_reg;
  assign is_halt   = w_head.is_halt;
  assign is_nop    = w_head.is_nop;
  assign illegal   = w_head.illegal;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, buffered instruction-decode stage for the pipelined WISC core. Sits between fetch and execute.
- Decodes the 5-bit opcode, instr[15:11], into the control bundle plus a resolved write-register index and decode-status flags.
- Queues decoded entries in a DEPTH-entry FIFO with valid/ready on both sides, and supports flush and sticky halt.

Parameters:
- INSTR_W, 16, instruction width; opcode is always instr[INSTR_W-1 -: 5].
- PC_W, 16, width of the PC carried alongside each instruction.
- DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_W  instruction word
- in_pc  in  PC_W  PC+2 of the instruction
- flush  in  1  discard all queued entries and clear halt
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction
- RegDst, RegSrc, Bsrc  out  2 each  control
- to_ALUOP  out  5  opcode
- brin  out  5  one-hot branch select
- _0ext, RegWrt, MemWrt, ALUJmp, ImmSrc  out  1 each  control
- wr_reg  out  3  resolved destination register
- is_halt, is_nop, illegal  out  1 each  decode status
- halted  out  1  sticky: halt accepted, input closed

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, all pointers and count 0, halted=0, out_valid=0. All head outputs read 0 while out_valid=0.
- Accept: push when in_valid && in_ready. in_ready = !full && !halted; there is no combinational path from out_ready.
- Pop: when out_valid && out_ready.
- Push and pop in the same cycle: count is unchanged.
- Decode timing: decode happens at push, and the decoded bundle is stored. Latency into an empty FIFO is 1 cycle (accepted at edge N, out_valid from N+1).
- Decode table. Unlisted fields are 0. `_0ext` defaults to 0.
  - 01000, 01001: RegDst 00, RegSrc 10, RegWrt, Bsrc 01.
  - 01010, 01011, 10100-10111: same as above, plus _0ext=1.
  - 10000: Bsrc 01, MemWrt.
  - 10001: RegSrc 01, RegWrt, Bsrc 01.
  - 10011: RegDst 01, RegSrc 10, RegWrt, MemWrt, Bsrc 01.
  - 11001-11111: RegDst 10, RegSrc 10, RegWrt, Bsrc 00.
  - 01100-01111: brin = 1 << opcode[1:0].
  - 11000: RegDst 01, RegSrc 11, RegWrt, Bsrc 10.
  - 10010: RegDst 01, RegSrc 11, _0ext, RegWrt, Bsrc 11.
  - 00100: brin 10000, ImmSrc.
  - 00101: Bsrc 10, ALUJmp.
  - 00110: RegDst 11, RegWrt, brin 10000, ImmSrc.
  - 00111: RegDst 11, RegWrt, Bsrc 10, ALUJmp.
  - 00000: is_halt. 00001: is_nop. 00010, 00011: illegal=1. All three have an all-zero bundle.
- wr_reg by RegDst: 00 selects instr[7:5], 01 selects instr[10:8], 10 selects instr[4:2], 11 selects 3'd7.
- to_ALUOP is always equal to the opcode.
- Halt:
  - Accepting an opcode-00000 instruction sets halted on the same edge. in_ready drops the next cycle.
  - Entries already queued, including the halt itself, still drain normally.
- Flush (synchronous):
  - Empties the FIFO and clears halted.
  - Flush wins over a simultaneous push and a simultaneous pop: both are dropped, and out_valid=0 the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are determined from count (log2(DEPTH)+1 bits).
- Backpressure: head outputs hold stable while out_valid && !out_ready.
- Reset mid-operation: asynchronous clear of all state, regardless of in-flight handshakes.

Decomposition:
- Shared package `wisc_pkg`:
  - opcode localparams (OP_HALT, OP_NOP, OP_J, ...).
  - RegDst/RegSrc/Bsrc encodings.
  - A packed `ctrl_t` struct of the bundle plus wr_reg and status bits.
- One combinational sub-module, `wisc_ctrl_decode`: instr in, `ctrl_t` out. decode_stage wraps it with the FIFO, handshake and halt/flush logic.

Test Plan:
- Reset, then push 0x4125 (opcode 01000) with out_ready=1 -> next cycle out_valid=1, RegSrc=10, Bsrc=01, RegWrt=1, _0ext=0, wr_reg=1 (instr[7:5]).
- Hold out_ready=0 and push 3 instructions, DEPTH=2 -> in_ready=0 after 2 accepts; the third is held until a pop; the head stays stable and order is preserved.
- Push 0x0000 (halt) followed by 0xD8E4 -> halted=1 and in_ready=0 after the halt. The halt reaches the output with is_halt=1, and 0xD8E4 is never accepted.
- With 2 entries queued, assert flush alongside in_valid and out_ready -> out_valid=0 next cycle, count=0, halted=0, and the pushed word is discarded.
- Opcodes 01100-01111 -> brin=00001, 00010, 00100, 01000. Opcode 00110 -> RegDst=11, wr_reg=7, brin=10000, ImmSrc=1.
- Opcode 00010 -> illegal=1 with an all-zero bundle. Drop rst_n mid-burst -> out_valid=0 and halted=0 immediately, without waiting for a clock edge.
